// File: rtl/and_64bit.sv
// Registered 64-bit bitwise AND unit for the Y86 ALU andq path.
// The result and the Y86 condition codes (ZF/SF/OF) are registered together with one cycle of latency.
module and_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic                    out_valid,
  output logic                    zf,
  output logic                    sf,
  output logic                    of
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] w;

  logic [WIDTH-1:0] c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  // One 1-bit AND gate per bit position; there is no carry or ripple between positions.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit_and
    assign w[i] = a[i] & b[i];
  end

  // Next-state logic: capture the new result and flags on a valid input, otherwise hold the result and drop valid.
  always_comb begin
    c_d         = c_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = 1'b0;
    out_valid_d = 1'b0;
    if (in_valid) begin
      c_d         = w;
      zf_d        = ~|w;
      sf_d        = w[MSB];
      out_valid_d = 1'b1;
    end
  end

  // State register. Asynchronous reset clears the result and loads the flags for a zero result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= WIDTH'(0);
      out_valid_q <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end

  assign c         = $signed(c_q);
  assign out_valid = out_valid_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_and_64bit.sv
// Bench for and_64bit: directed Y86 cases followed by a random sweep checked against a reference model.
module tb_and_64bit;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [63:0] a;
  logic signed [63:0] b;
  logic signed [63:0] c;
  logic               out_valid;
  logic               zf;
  logic               sf;
  logic               of;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: the result most recently captured, and whether it is fresh.
  logic [63:0] exp_c = 64'd0;
  logic        exp_v = 1'b0;

  and_64bit #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare every output against the model. The flags are derived from the value of the result.
  task automatic check_all(input string tag);
    check({tag, ".c"},  64'(c), exp_c);
    check({tag, ".ov"}, 64'(out_valid), 64'(exp_v));
    check({tag, ".zf"}, 64'(zf), 64'(exp_c == 64'd0));
    check({tag, ".sf"}, 64'(sf), 64'($signed(exp_c) < 0));
    check({tag, ".of"}, 64'(of), 64'd0);
  endtask

  // Drive one cycle, advance the model at the edge, and check just after the edge.
  task automatic step(input string tag, input logic v, input logic [63:0] av, input logic [63:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    if (rst) begin
      exp_c = 64'd0;
      exp_v = 1'b0;
    end else if (v) begin
      exp_c = av & bv;
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rv;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 64'd0;
    b        = 64'd0;

    // Reset holds outputs at their reset values even with valid operands presented.
    step("reset_hold", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_c_zero", 64'(c), 64'd0);
    #2 rst = 1'b0;

    // All ones gives -1 with the sign flag set.
    step("all_ones", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("all_ones_const", 64'(c), 64'hFFFF_FFFF_FFFF_FFFF);

    step("small_pos", 1'b1, 64'd1134, 64'd8238);
    check("small_pos_const", 64'(c), 64'd46);
    step("zeros", 1'b1, 64'd0, 64'd0);
    check("zeros_zf", 64'(zf), 64'd1);

    step("neg_neg", 1'b1, 64'(-64'sd7478), 64'(-64'sd46474));
    check("neg_neg_const", 64'(c), 64'hFFFF_FFFF_FFFF_4242);
    step("pos_neg", 1'b1, 64'd1092835, 64'(-64'sd1020));
    check("pos_neg_const", 64'(c), 64'h0000_0000_0010_AC00);

    step("large", 1'b1, 64'd7890678653, 64'd4238598110567);
    step("idle_hold", 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
    step("idle_hold2", 1'b0, 64'h0, 64'h0);

    // Asynchronous reset between edges clears outputs immediately.
    step("pre_rst", 1'b1, 64'h8000_0000_0000_00FF, 64'hF000_0000_0000_000F);
    #2 rst = 1'b1;
    #1;
    exp_c = 64'd0;
    exp_v = 1'b0;
    check_all("async_rst");
    // An operand in flight while reset is held is discarded.
    step("rst_discard", 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF);
    #2 rst = 1'b0;
    step("post_rst", 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFF00_FF00_FF00_FF00);

    // Random sweep, occasionally forcing a zero operand or idle cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) ra = 64'd0;
      if ($urandom_range(0, 15) == 0) rb = ~ra;
      rv = ($urandom_range(0, 4) != 0);
      step("random", rv, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
